clk_ctrl: RTL and testbench

CLK_CTRL -- requirements
Module: clk_ctrl

---
 rtl/clk_ctrl_pkg.sv | 19 +
 rtl/clk_ctrl_if.sv | 9 +
 rtl/clk_ctrl_key_debounce.sv | 53 +++++
 rtl/clk_ctrl.sv | 97 +++++++++
 tb/tb_clk_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared constants for the clock controller: default timing parameters,
// pushbutton indices and the counter-width helper.
package clk_ctrl_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_SLOW_HALF       = 10000000;
  localparam int DEF_FAST_HALF       = 31;
  localparam int DEF_MEM_HALF        = 5;

  localparam int STEP     = 3;
  localparam int SEL_AUTO = 2;
  localparam int SEL_FAST = 1;

  // A counter running 0..n-1 needs clog2(n) bits; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_ctrl_if.sv
// One pushbutton channel: raw active-low key in, one-cycle press event out.
// press is high for exactly one iCLK_50 cycle per accepted press; there is no back-pressure.
interface clk_ctrl_if;
  logic raw;
  logic press;

  modport master (input raw, output press);
  modport slave  (output raw, input press);
endinterface

// File: rtl/clk_ctrl_key_debounce.sv
// Synchronizer, debouncer and falling-edge detector for one active-low key.
// press is combinational and marks the cycle whose edge commits a new low level.
module key_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  clk_ctrl_if.master    key
);

  localparam int W = cnt_width(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [1:0]   sync_q;
  logic [1:0]   settle;
  logic         sync;
  logic         level;
  logic         armed;
  logic         done;
  logic [W-1:0] cnt;

  assign sync      = sync_q[1];
  assign done      = (sync != level) && (cnt == LAST);
  assign key.press = done && !sync && armed;

  // armed only once the key has been seen released after reset, so a press
  // held through reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      settle <= 2'b00;
      level  <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], key.raw};
      settle <= {settle[0], 1'b1};
      if (settle[1] && sync && level)
        armed <= 1'b1;
      if (sync == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// Processor/memory clock controller: manual single-step or auto slow/fast
// clock selected by debounced pushbuttons, all logic on iCLK_50.
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SLOW_HALF       = DEF_SLOW_HALF,
  parameter int FAST_HALF       = DEF_FAST_HALF,
  parameter int MEM_HALF        = DEF_MEM_HALF
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic [3:1] iKEY,
  output logic       oCLK,
  output logic       oCLKMem,
  output logic       oSelAuto,
  output logic       oSelFast,
  output logic       oStepPulse
);

  localparam int SLOW_W = cnt_width(SLOW_HALF);
  localparam int FAST_W = cnt_width(FAST_HALF);
  localparam int MEM_W  = cnt_width(MEM_HALF);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);
  localparam logic [MEM_W-1:0]  MEM_LAST  = MEM_W'(MEM_HALF - 1);

  clk_ctrl_if step_key ();
  clk_ctrl_if auto_key ();
  clk_ctrl_if fast_key ();

  assign step_key.raw = iKEY[STEP];
  assign auto_key.raw = iKEY[SEL_AUTO];
  assign fast_key.raw = iKEY[SEL_FAST];

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (.clk(iCLK_50), .rst(iRST), .key(step_key));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_auto (.clk(iCLK_50), .rst(iRST), .key(auto_key));
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_fast (.clk(iCLK_50), .rst(iRST), .key(fast_key));

  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;
  logic [MEM_W-1:0]  mem_cnt;
  logic              slow_lvl;
  logic              fast_lvl;
  logic              mem_lvl;
  logic              manual_lvl;

  // Free-running dividers; select changes never touch them.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      mem_cnt  <= '0;
      slow_lvl <= 1'b0;
      fast_lvl <= 1'b0;
      mem_lvl  <= 1'b0;
    end else begin
      if (slow_cnt == SLOW_LAST) begin
        slow_cnt <= '0;
        slow_lvl <= ~slow_lvl;
      end else begin
        slow_cnt <= slow_cnt + 1'b1;
      end
      if (fast_cnt == FAST_LAST) begin
        fast_cnt <= '0;
        fast_lvl <= ~fast_lvl;
      end else begin
        fast_cnt <= fast_cnt + 1'b1;
      end
      if (mem_cnt == MEM_LAST) begin
        mem_cnt <= '0;
        mem_lvl <= ~mem_lvl;
      end else begin
        mem_cnt <= mem_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      manual_lvl <= 1'b0;
      oStepPulse <= 1'b0;
      oSelAuto   <= 1'b0;
      oSelFast   <= 1'b0;
      oCLK       <= 1'b0;
    end else begin
      manual_lvl <= manual_lvl ^ step_key.press;
      oStepPulse <= step_key.press;
      oSelAuto   <= oSelAuto ^ auto_key.press;
      oSelFast   <= oSelFast ^ fast_key.press;
      oCLK       <= oSelAuto ? (oSelFast ? fast_lvl : slow_lvl) : manual_lvl;
    end
  end

  assign oCLKMem = mem_lvl;

endmodule

// File: tb/tb_clk_ctrl.sv
// Directed bench for clk_ctrl with short debounce and divider settings.
module tb_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:1] key;
  logic       o_clk;
  logic       o_clk_mem;
  logic       o_sel_auto;
  logic       o_sel_fast;
  logic       o_step_pulse;

  int n_cmp = 0;
  int n_err = 0;

  clk_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_HALF(8),
    .FAST_HALF(3),
    .MEM_HALF(2)
  ) dut (
    .iCLK_50(clk),
    .iRST(rst),
    .iKEY(key),
    .oCLK(o_clk),
    .oCLKMem(o_clk_mem),
    .oSelAuto(o_sel_auto),
    .oSelFast(o_sel_fast),
    .oStepPulse(o_step_pulse)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key = 3'b111;
    wait_cycles(3);
    rst = 1'b0;
  endtask

  // Cycles between two consecutive transitions of oCLK or oCLKMem; -1 on timeout.
  task automatic measure_gap(input bit use_mem, output int gap);
    logic prev;
    logic cur;
    int first;
    gap   = -1;
    first = -1;
    prev  = use_mem ? o_clk_mem : o_clk;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      cur = use_mem ? o_clk_mem : o_clk;
      if (cur !== prev) begin
        if (first < 0) begin
          first = n;
        end else begin
          gap = n - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    int gap;
    int pulses;
    @(negedge clk);
    rst = 1'b1;
    key = 3'b111;
    wait_cycles(3);
    n_cmp++;
    if ({o_clk, o_clk_mem, o_sel_auto, o_sel_fast, o_step_pulse} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {o_clk, o_clk_mem, o_sel_auto, o_sel_fast, o_step_pulse});
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_step_pulse === 1'b1) pulses++;
      n_cmp++;
      if ({o_clk, o_sel_auto, o_sel_fast} !== 3'b000) begin
        n_err++;
        $display("FAIL idle_outputs cycle %0d: clk/auto/fast %b expected 000", i,
                 {o_clk, o_sel_auto, o_sel_fast});
      end
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL idle_pulse: got %0d pulses expected 0", pulses);
    end
    measure_gap(1'b1, gap);
    n_cmp++;
    if (gap !== 2) begin
      n_err++;
      $display("FAIL mem_period: got gap %0d expected 2", gap);
    end
  endtask

  task automatic test_step();
    key[3] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_step_pulse !== (i == 6)) begin
        n_err++;
        $display("FAIL step_pulse cycle %0d: got %b expected %b", i, o_step_pulse, (i == 6));
      end
      if (i == 6 || i == 7) begin
        n_cmp++;
        if (o_clk !== (i == 7)) begin
          n_err++;
          $display("FAIL step_clk cycle %0d: got %b expected %b", i, o_clk, (i == 7));
        end
      end
      if (i == 10) key[3] = 1'b1;
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    key[3] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (o_step_pulse === 1'b1) pulses++;
      if (i == 3) key[3] = 1'b1;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL glitch_pulse: got %0d pulses expected 0", pulses);
    end
    n_cmp++;
    if (o_clk !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_clk: got %b expected 1", o_clk);
    end
  endtask

  task automatic test_auto_slow();
    int gap;
    key[2] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5 || i == 6) begin
        n_cmp++;
        if (o_sel_auto !== (i == 6)) begin
          n_err++;
          $display("FAIL sel_auto cycle %0d: got %b expected %b", i, o_sel_auto, (i == 6));
        end
      end
    end
    key[2] = 1'b1;
    wait_cycles(10);
    for (int k = 0; k < 2; k++) begin
      measure_gap(1'b0, gap);
      n_cmp++;
      if (gap !== 8) begin
        n_err++;
        $display("FAIL slow_period %0d: got gap %0d expected 8", k, gap);
      end
    end
  endtask

  task automatic test_fast();
    int gap;
    key[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5 || i == 6) begin
        n_cmp++;
        if (o_sel_fast !== (i == 6)) begin
          n_err++;
          $display("FAIL sel_fast cycle %0d: got %b expected %b", i, o_sel_fast, (i == 6));
        end
      end
    end
    key[1] = 1'b1;
    wait_cycles(10);
    n_cmp++;
    if (o_sel_auto !== 1'b1) begin
      n_err++;
      $display("FAIL fast_keeps_auto: got %b expected 1", o_sel_auto);
    end
    for (int k = 0; k < 2; k++) begin
      measure_gap(1'b0, gap);
      n_cmp++;
      if (gap !== 3) begin
        n_err++;
        $display("FAIL fast_period %0d: got gap %0d expected 3", k, gap);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wait_cycles(6);
    key[2:1] = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5 || i == 6) begin
        n_cmp++;
        if ({o_sel_auto, o_sel_fast} !== ((i == 6) ? 2'b11 : 2'b00)) begin
          n_err++;
          $display("FAIL simul_sel cycle %0d: got %b expected %b", i,
                   {o_sel_auto, o_sel_fast}, ((i == 6) ? 2'b11 : 2'b00));
        end
      end
    end
    key[2:1] = 2'b11;
    wait_cycles(10);
  endtask

  task automatic test_reset_mid_debounce();
    int pulses;
    do_reset();
    wait_cycles(6);
    key[3] = 1'b0;
    wait_cycles(4);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_clk, o_clk_mem, o_sel_auto, o_sel_fast, o_step_pulse} !== 5'b00000) begin
        n_err++;
        $display("FAIL mid_reset_outputs cycle %0d: got %b expected 00000", i,
                 {o_clk, o_clk_mem, o_sel_auto, o_sel_fast, o_step_pulse});
      end
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_step_pulse === 1'b1) pulses++;
    end
    key[3] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (o_step_pulse === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL held_through_reset: got %0d pulses expected 0", pulses);
    end
    key[3] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_step_pulse !== (i == 6)) begin
        n_err++;
        $display("FAIL repress_pulse cycle %0d: got %b expected %b", i, o_step_pulse, (i == 6));
      end
    end
    key[3] = 1'b1;
    wait_cycles(10);
  endtask

  initial begin
    rst = 1'b1;
    key = 3'b111;
    test_reset();
    test_step();
    test_glitch();
    test_auto_slow();
    test_fast();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
